// File: rtl/boot_rom_pkg.sv
// Shared defaults and helpers for the boot ROM arbiter slice.
package boot_rom_pkg;

  localparam int ROM_NUM_PORTS  = 3;
  localparam int ROM_ADDR_WIDTH = 11;
  localparam int ROM_DATA_WIDTH = 32;

  // Width of a port index; a single-port build still gets one bit.
  function automatic int idx_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/boot_rom_arbiter_if.sv
// Requester-side req/gnt/rvalid bus shared by all boot ROM requesters.
interface boot_rom_arbiter_if
  import boot_rom_pkg::*;
#(
  parameter int NUM_PORTS  = ROM_NUM_PORTS,
  parameter int DATA_WIDTH = ROM_DATA_WIDTH
);

  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0][31:0]  addr;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        rvalid;
  logic [DATA_WIDTH-1:0]       rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/boot_rom_rr_arb.sv
// Combinational round-robin search: first asserted request at or after rr_ptr wins.
module boot_rom_rr_arb
  import boot_rom_pkg::*;
#(
  parameter int NUM_PORTS = ROM_NUM_PORTS,
  parameter int IDX_W     = idx_width(ROM_NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     winner,
  output logic                 any_gnt
);

  // Walk the ports once starting at rr_ptr; each index is visited exactly once.
  always_comb begin
    int   idx;
    logic take;
    gnt     = '0;
    winner  = '0;
    any_gnt = 1'b0;
    idx     = 0;
    take    = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx      = (int'(rr_ptr) + k) % NUM_PORTS;
      take     = req[idx] & ~any_gnt;
      gnt[idx] = take;
      winner   = take ? IDX_W'(idx) : winner;
      any_gnt  = any_gnt | take;
    end
  end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Shares a single-port boot ROM macro between NUM_PORTS word-read requesters
// with round-robin arbitration and one grant per cycle.
module boot_rom_arbiter
  import boot_rom_pkg::*;
#(
  parameter int NUM_PORTS  = ROM_NUM_PORTS,
  parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROM_DATA_WIDTH,
  parameter bit OUT_REG    = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  boot_rom_arbiter_if.slave     bus,
  output logic                  rom_cen_o,
  output logic [ADDR_WIDTH-1:0] rom_a_o,
  input  logic [DATA_WIDTH-1:0] rom_q_i
);

  localparam int IDX_W = idx_width(NUM_PORTS);
  typedef logic [IDX_W-1:0] port_idx_t;

  logic                  en_r;
  port_idx_t             rr_ptr_r;
  port_idx_t             rr_next_s;
  port_idx_t             winner_s;
  port_idx_t             rsp_id_r;
  logic                  rsp_valid_r;
  logic [NUM_PORTS-1:0]  req_s;
  logic [NUM_PORTS-1:0]  gnt_s;
  logic [NUM_PORTS-1:0]  rvalid_s;
  logic                  any_gnt_s;
  logic [ADDR_WIDTH-1:0] a_sel_s;
  logic [ADDR_WIDTH-1:0] a_hold_r;
  logic                  unused_addr_bits_s;

  // Byte offset and bits above the ROM range are deliberately dropped.
  assign unused_addr_bits_s = ^bus.addr;

  assign req_s = en_r ? bus.req : '0;

  boot_rom_rr_arb #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_arb (
    .req     (req_s),
    .rr_ptr  (rr_ptr_r),
    .gnt     (gnt_s),
    .winner  (winner_s),
    .any_gnt (any_gnt_s)
  );

  assign bus.gnt = gnt_s;

  // ROM drive: the address holds its last granted value while idle.
  always_comb begin
    a_sel_s   = bus.addr[winner_s][ADDR_WIDTH+1:2];
    rom_cen_o = ~any_gnt_s;
    rom_a_o   = any_gnt_s ? a_sel_s : a_hold_r;
    rr_next_s = port_idx_t'((int'(winner_s) + 1) % NUM_PORTS);
  end

  // Enable, fairness pointer and address hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_r     <= 1'b0;
      rr_ptr_r <= '0;
      a_hold_r <= '0;
    end else begin
      en_r     <= 1'b1;
      rr_ptr_r <= any_gnt_s ? rr_next_s : rr_ptr_r;
      a_hold_r <= rom_a_o;
    end
  end

  // Tracks which port owns the read whose data appears on rom_q_i next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
    end else begin
      rsp_valid_r <= any_gnt_s;
      rsp_id_r    <= any_gnt_s ? winner_s : rsp_id_r;
    end
  end

  // Decode the owning port into a one-hot valid pulse.
  always_comb begin
    rvalid_s           = '0;
    rvalid_s[rsp_id_r] = rsp_valid_r;
  end

  if (OUT_REG) begin : g_out_reg
    logic [NUM_PORTS-1:0]  rvalid_r;
    logic [DATA_WIDTH-1:0] rdata_r;

    // Output stage; data only updates when a response is delivered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rvalid_r <= '0;
        rdata_r  <= '0;
      end else begin
        rvalid_r <= rvalid_s;
        rdata_r  <= rsp_valid_r ? rom_q_i : rdata_r;
      end
    end

    assign bus.rvalid = rvalid_r;
    assign bus.rdata  = rdata_r;
  end else begin : g_out_comb
    assign bus.rvalid = rvalid_s;
    assign bus.rdata  = rom_q_i;
  end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Self-checking bench: OUT_REG=0 and OUT_REG=1 instances share stimulus and are
// compared every cycle against a queue-based model of the arbitration rules.
module tb_boot_rom_arbiter;
  import boot_rom_pkg::*;

  localparam int NP = 3;
  localparam int AW = 11;
  localparam int DW = 32;

  typedef struct {
    int port;
    int word;
    int due;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0]       req = '0;
  logic [NP-1:0][31:0] addr = '0;
  logic          cen0, cen1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] q0 = '0;
  logic [DW-1:0] q1 = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rr = 0;
  bit en = 1'b0;
  int hold_a = 0;
  logic [DW-1:0] last_d2 = '0;
  rsp_t q_l1[$];
  rsp_t q_l2[$];

  always #5 clk = ~clk;

  boot_rom_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus0 ();
  boot_rom_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.req  = req;
  assign bus0.addr = addr;
  assign bus1.req  = req;
  assign bus1.addr = addr;

  boot_rom_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave),
    .rom_cen_o(cen0), .rom_a_o(a0), .rom_q_i(q0));

  boot_rom_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave),
    .rom_cen_o(cen1), .rom_a_o(a1), .rom_q_i(q1));

  function automatic logic [DW-1:0] rom_word(input int w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Single-port ROM macros: Q updates the cycle after CEN=0, otherwise holds.
  always @(posedge clk) begin
    if (!cen0) q0 <= rom_word(int'(a0));
    if (!cen1) q1 <= rom_word(int'(a1));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rr = 0;
    en = 1'b0;
    hold_a = 0;
    last_d2 = '0;
    q_l1.delete();
    q_l2.delete();
  endtask

  // One clock cycle: apply inputs, check all outputs, advance the model.
  task automatic step(input logic [NP-1:0] r, input logic [NP-1:0][31:0] ad, input bit rst_mid = 1'b0);
    int w;
    int p;
    logic [NP-1:0] eg;
    logic [NP-1:0] erv0;
    logic [NP-1:0] erv1;
    rsp_t rs;
    req = r;
    addr = ad;
    #1;
    w = -1;
    if (en) begin
      for (int k = 0; k < NP; k++) begin
        p = (rr + k) % NP;
        if (w < 0 && r[p]) w = p;
      end
    end
    eg = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      hold_a = int'(ad[w][AW+1:2]);
    end
    chk("gnt0", 64'(bus0.gnt), 64'(eg));
    chk("gnt1", 64'(bus1.gnt), 64'(eg));
    chk("cen0", 64'(cen0), 64'(w < 0));
    chk("cen1", 64'(cen1), 64'(w < 0));
    chk("rom_a0", 64'(a0), 64'(hold_a));
    chk("rom_a1", 64'(a1), 64'(hold_a));
    erv0 = '0;
    if (q_l1.size() > 0 && q_l1[0].due == cyc) begin
      rs = q_l1.pop_front();
      erv0[rs.port] = 1'b1;
      chk("rdata0", 64'(bus0.rdata), 64'(rom_word(rs.word)));
    end
    chk("rvalid0", 64'(bus0.rvalid), 64'(erv0));
    erv1 = '0;
    if (q_l2.size() > 0 && q_l2[0].due == cyc) begin
      rs = q_l2.pop_front();
      erv1[rs.port] = 1'b1;
      last_d2 = rom_word(rs.word);
    end
    chk("rvalid1", 64'(bus1.rvalid), 64'(erv1));
    chk("rdata1", 64'(bus1.rdata), 64'(last_d2));
    if (w >= 0) begin
      q_l1.push_back('{port: w, word: hold_a, due: cyc + 1});
      q_l2.push_back('{port: w, word: hold_a, due: cyc + 2});
      rr = (w + 1) % NP;
    end
    if (rst_mid) begin
      rst_n = 1'b0;
      model_reset();
    end
    @(posedge clk);
    if (rst_n) en = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, addr);
  endtask

  initial begin
    @(negedge clk);
    model_reset();
    step('0, '0);
    rst_n = 1'b1;

    // Release: first cycle has no grant, then port0 reads word 4.
    step(3'b001, {32'h0, 32'h0, 32'h10});
    step(3'b001, {32'h0, 32'h0, 32'h10});
    idle(3);

    // All ports requesting continuously with distinct addresses.
    for (int i = 0; i < 6; i++) step(3'b111, {32'h0000_0300, 32'h0000_0200, 32'h0000_0100});
    idle(3);

    // Port1 back-to-back words 5, 6, 7.
    step(3'b010, {32'h0, 32'd20, 32'h0});
    step(3'b010, {32'h0, 32'd24, 32'h0});
    step(3'b010, {32'h0, 32'd28, 32'h0});
    idle(3);

    // Reset between grant and response; port0 wins first afterwards.
    step(3'b001, {32'h0, 32'h0, 32'h40});
    step(3'b001, {32'h0, 32'h0, 32'h40}, 1'b1);
    step('0, '0);
    step('0, '0);
    rst_n = 1'b1;
    step(3'b111, {32'h0000_0308, 32'h0000_0208, 32'h0000_0108});
    step(3'b111, {32'h0000_0308, 32'h0000_0208, 32'h0000_0108});
    idle(3);

    // Top word with junk in the ignored address bits; rdata of the registered copy holds.
    step(3'b100, {32'hABCD_1FFF, 32'h0, 32'h0});
    idle(4);

    // Idle after word 9: CEN stays high, address stays 9.
    step(3'b001, {32'h0, 32'h0, 32'h24});
    idle(10);

    for (int i = 0; i < 300; i++)
      step(3'($urandom_range(0, 7)), {$urandom(), $urandom(), $urandom()});
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
